ps2_key_event_fifo: RTL and testbench

PS2_KEY_EVENT_FIFO -- requirements
Module: ps2_key_event_fifo

---
 rtl/ps2_key_event_fifo.sv | 150 +++++++++++++++
 tb/tb_ps2_key_event_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-code decoder (E0/F0 prefixes) feeding a show-ahead event FIFO.
// Optional typematic repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_fifo #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
    input  logic                     inclock,
    input  logic                     resetn,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     rd_en,
    output logic [9:0]               event_data,
    output logic                     event_valid,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [9:0]               last_event
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned TW      = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LIM = (PREFIX_TIMEOUT == 0) ? 0 : PREFIX_TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            tmo_hit;
    logic            cand, cand_ext, cand_brk;
    logic [9:0]      cand_ev;
    logic            emit;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_q;
    logic            full_c, pop_c, push_c;

    assign tmo_hit = (PREFIX_TIMEOUT != 0) && (state_q != IDLE) && (tmo_q == TW'(TMO_LIM));
    assign cand_ev = {cand_ext, cand_brk, byte_in};

    // Decoder state register and prefix idle counter
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        cand     = 1'b0;
        cand_ext = 1'b0;
        cand_brk = 1'b0;
        if (byte_valid) begin
            case (byte_in)
                8'h00, 8'hFF: state_d = IDLE;
                8'hE0:        state_d = GOT_E0;
                8'hF0: begin
                    case (state_q)
                        IDLE:    state_d = GOT_F0;
                        GOT_E0:  state_d = GOT_E0F0;
                        default: state_d = state_q;
                    endcase
                end
                default: begin
                    cand     = 1'b1;
                    cand_ext = (state_q == GOT_E0) || (state_q == GOT_E0F0);
                    cand_brk = (state_q == GOT_F0) || (state_q == GOT_E0F0);
                    state_d  = IDLE;
                end
            endcase
        end else if (tmo_hit) begin
            state_d = IDLE;
        end else if ((state_q != IDLE) && (PREFIX_TIMEOUT != 0)) begin
            tmo_d = TW'(tmo_q + 1'b1);
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_match;

    assign held_match = held_valid && (held_ext == cand_ext) && (held_code == byte_in);
    assign emit       = cand && !(held_match && !cand_brk);

    // Held key: repeated makes are suppressed until its break arrives
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= 8'h00;
        end else if (cand) begin
            if (!cand_brk) begin
                if (!held_match) begin
                    held_valid <= 1'b1;
                    held_ext   <= cand_ext;
                    held_code  <= byte_in;
                end
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign emit = cand;
`endif

    assign full_c = (count_q == CW'(DEPTH));
    assign pop_c  = rd_en && (count_q != '0);
    assign push_c = emit && (!full_c || pop_c);

    // FIFO pointers, occupancy, sticky overflow and last emitted event
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            last_event <= 10'h000;
        end else begin
            if (push_c) wr_ptr <= AW'(wr_ptr + 1'b1);
            if (pop_c)  rd_ptr <= AW'(rd_ptr + 1'b1);
            case ({push_c, pop_c})
                2'b10:   count_q <= CW'(count_q + 1'b1);
                2'b01:   count_q <= CW'(count_q - 1'b1);
                default: count_q <= count_q;
            endcase
            if (emit && full_c && !pop_c) overflow <= 1'b1;
            if (emit) last_event <= cand_ev;
        end
    end

    // Storage is don't-care until written, so it carries no reset
    always_ff @(posedge inclock) begin
        if (resetn && push_c) mem[wr_ptr] <= cand_ev;
    end

    assign event_data  = mem[rd_ptr];
    assign event_valid = (count_q != '0);
    assign fifo_full   = full_c;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: directed scenarios plus random
// byte streams compared against a flag/queue model of the decoder and FIFO.
module tb_ps2_key_event_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic         inclock = 1'b0;
    logic         resetn;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         rd_en;
    logic [9:0]   event_data;
    logic         event_valid;
    logic         fifo_full;
    logic [3:0]   fifo_count;
    logic         overflow;
    logic [9:0]   last_event;

    int tests = 0;
    int fails = 0;

    ps2_key_event_fifo #(.DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
        .inclock     (inclock),
        .resetn      (resetn),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .rd_en       (rd_en),
        .event_data  (event_data),
        .event_valid (event_valid),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .last_event  (last_event)
    );

    always #5 inclock = ~inclock;

    // Reference model: pending prefix flags, quiet-cycle count, event queue
    logic [9:0] mq [$];
    bit         pe, pb;
    int         quiet;
    bit         m_ovf;
    logic [9:0] m_last;
    bit         h_valid;
    logic [8:0] h_key;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic bv, input logic [7:0] b, input logic rd);
        bit         pop, have_ev, supp, was_full;
        logic [9:0] ev;
        if (!resetn) begin
            mq.delete();
            pe = 0; pb = 0; quiet = 0; m_ovf = 0; m_last = '0; h_valid = 0; h_key = '0;
            return;
        end
        pop = rd && (mq.size() != 0);
        was_full = (mq.size() == DEPTH);
        have_ev = 0; supp = 0; ev = '0;
        if (bv) begin
            quiet = 0;
            if (b == 8'hE0) begin pe = 1; pb = 0; end
            else if (b == 8'hF0) pb = 1;
            else if (b == 8'h00 || b == 8'hFF) begin pe = 0; pb = 0; end
            else begin
                ev = {pe, pb, b}; have_ev = 1; pe = 0; pb = 0;
            end
        end else if (pe || pb) begin
            quiet++;
            if (quiet == TMO) begin pe = 0; pb = 0; quiet = 0; end
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (have_ev) begin
            if (!ev[8]) begin
                if (h_valid && h_key == {ev[9], ev[7:0]}) supp = 1;
                else begin h_valid = 1; h_key = {ev[9], ev[7:0]}; end
            end else if (h_valid && h_key == {ev[9], ev[7:0]}) h_valid = 0;
        end
`endif
        if (pop) void'(mq.pop_front());
        if (have_ev && !supp) begin
            m_last = ev;
            if (was_full && !pop) m_ovf = 1;
            else mq.push_back(ev);
        end
    endtask

    task automatic compare_all();
        check("event_valid", 32'(event_valid), 32'(mq.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("last_event", 32'(last_event), 32'(m_last));
        if (mq.size() != 0) check("event_data", 32'(event_data), 32'(mq[0]));
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic rd);
        byte_valid = bv; byte_in = b; rd_en = rd;
        @(posedge inclock);
        model_update(bv, b, rd);
        #1;
        byte_valid = 1'b0; rd_en = 1'b0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pop_expect(input logic [9:0] exp);
        check("head", 32'(event_data), 32'(exp));
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1'b1, 8'hE0, 1'b1);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; rd_en = 1'b0;
        pe = 0; pb = 0; quiet = 0; m_ovf = 0; m_last = '0; h_valid = 0; h_key = '0;

        // Reset state; a prefix byte during reset must be ignored
        step(1'b1, 8'hE0, 1'b1);
        step(1'b1, 8'hE0, 1'b0);
        check("rst_event_valid", 32'(event_valid), 32'd0);
        check("rst_last_event", 32'(last_event), 32'h000);
        resetn = 1'b1;
        send(8'h1C);
        check("post_rst_byte", 32'(last_event), 32'h01C);
        pop_expect(10'h01C);

        // Make then break
        send(8'h1C); send(8'hF0); send(8'h1C);
        check("brk_last", 32'(last_event), 32'h11C);
        pop_expect(10'h01C);
        pop_expect(10'h11C);

        // Extended make/break, repeated F0 ignored
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'hF0); send(8'h75);
        pop_expect(10'h275);
        pop_expect(10'h375);
        pop_expect(10'h375);

        // 00/FF abort a prefix without an event; read of empty FIFO ignored
        send(8'hE0); send(8'hFF); send(8'h2A);
        pop_expect(10'h02A);
        step(1'b0, 8'h00, 1'b1);
        check("empty_pop_count", 32'(fifo_count), 32'd0);

        // Mid-prefix reset discards the prefix
        send(8'hE0);
        do_reset();
        send(8'h33);
        check("rst_mid_prefix", 32'(last_event), 32'h033);
        pop_expect(10'h033);

        // Overflow: nine makes into a depth-8 FIFO
        do_reset();
        for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(event_data), 32'h010);
        for (int i = 0; i < 8; i++) pop_expect(10'(10'h010 + i));
        check("ovf_drained", 32'(event_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Write and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i));
        step(1'b1, 8'h28, 1'b1);
        check("fullrw_count", 32'(fifo_count), 32'd8);
        check("fullrw_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) pop_expect(10'(10'h020 + i));

        // Prefix timeout, including the exact boundary
        send(8'hE0); idle(20); send(8'h1C);
        check("tmo_20", 32'(last_event), 32'h01C);
        pop_expect(10'h01C);
        send(8'hE0); idle(8); send(8'h1C);
        check("tmo_8", 32'(last_event), 32'h21C);
        pop_expect(10'h21C);
        send(8'hE0); idle(15); send(8'h1D);
        check("tmo_15", 32'(last_event), 32'h21D);
        pop_expect(10'h21D);
        send(8'hE0); idle(16); send(8'h1D);
        check("tmo_16", 32'(last_event), 32'h01D);
        pop_expect(10'h01D);

        // Typematic repeat sequence
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic_count", 32'(fifo_count), 32'd3);
        pop_expect(10'h01C); pop_expect(10'h11C); pop_expect(10'h01C);
`else
        check("typematic_count", 32'(fifo_count), 32'd5);
        pop_expect(10'h01C); pop_expect(10'h01C); pop_expect(10'h01C);
        pop_expect(10'h11C); pop_expect(10'h01C);
`endif

        // Random streams against the model
        for (int n = 0; n < 3000; n++) begin
            int         r;
            int         k;
            logic [7:0] b;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset();
            end else if (r < 15) begin
                idle(int'($urandom_range(12, 20)));
            end else begin
                k = int'($urandom_range(0, 11));
                case (k)
                    0, 1:    b = 8'hE0;
                    2, 3:    b = 8'hF0;
                    4:       b = 8'h00;
                    5:       b = 8'hFF;
                    6, 7, 8: b = 8'h1C;
                    9:       b = 8'h1D;
                    default: b = 8'($urandom);
                endcase
                step(1'($urandom_range(0, 99) < 45), b, 1'($urandom_range(0, 99) < 30));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
